// File: rtl/clk_gate_ctrl_fg.sv
// Fine-grained clock-gate enable controller: drains an idle stage, gates it,
// and re-enables it with a fixed settle window on wake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ON    | clock running, stage ready, counting consecutive idle cycles
// ST_PEND  | idle window expired, gateReq_o raised, waiting for gateAck_i
// ST_GATED | enable low, stage clock stopped
// ST_WAKE  | enable high again, ready_o held low while the clock settles
module clk_gate_ctrl_fg #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 4,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy_i,
    input  logic              wakeReq_i,
    input  logic              forceOn_i,
    input  logic              gateAck_i,
    output logic              gateReq_o,
    output logic              clkEn_o,
    output logic              ready_o,
    output logic              gated_o,
    output logic [STAT_W-1:0] gateCnt_o
);

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_PEND  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic [CNT_W-1:0]   wake_cnt_q;
    logic               gate_req_q;
    logic               clk_en_q;
    logic               ready_q;
    logic               gated_q;
    logic [STAT_W-1:0]  gate_cnt_q;
    logic [STAT_W-1:0]  gate_cnt_d;
    logic               active;

    assign active     = busy_i | wakeReq_i | forceOn_i;
    assign gate_cnt_d = (&gate_cnt_q) ? gate_cnt_q : gate_cnt_q + STAT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ON;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_req_q <= 1'b0;
            clk_en_q   <= 1'b1;
            ready_q    <= 1'b1;
            gated_q    <= 1'b0;
            gate_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_ON: begin
                    if (active) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_q <= '0;
                        gate_req_q <= 1'b1;
                        state_q    <= ST_PEND;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                    end
                end
                ST_PEND: begin
                    // Activity wins over a same-cycle acknowledge.
                    if (active) begin
                        gate_req_q <= 1'b0;
                        state_q    <= ST_ON;
                    end else if (gateAck_i) begin
                        gate_req_q <= 1'b0;
                        clk_en_q   <= 1'b0;
                        ready_q    <= 1'b0;
                        gated_q    <= 1'b1;
                        gate_cnt_q <= gate_cnt_d;
                        state_q    <= ST_GATED;
                    end
                end
                ST_GATED: begin
                    if (active) begin
                        wake_cnt_q <= '0;
                        clk_en_q   <= 1'b1;
                        gated_q    <= 1'b0;
                        state_q    <= ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_q == WAKE_LAST) begin
                        wake_cnt_q <= '0;
                        ready_q    <= 1'b1;
                        state_q    <= ST_ON;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_ON;
            endcase
        end
    end

    assign gateReq_o = gate_req_q;
    assign clkEn_o   = clk_en_q;
    assign ready_o   = ready_q;
    assign gated_o   = gated_q;
    assign gateCnt_o = gate_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl_fg.sv
// Scoreboard bench for clk_gate_ctrl_fg: two instances (16-bit and 2-bit
// event counter) share stimulus and are checked against a timing-level model.
module tb_clk_gate_ctrl_fg;

    localparam int IDLE = 8;
    localparam int WAKE = 2;

    logic clk = 1'b0;
    logic reset, busy, wake, force_on, ack;

    logic        req_a, en_a, rdy_a, gtd_a;
    logic [15:0] cnt_a;
    logic        req_b, en_b, rdy_b, gtd_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    clk_gate_ctrl_fg #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(4), .STAT_W(16)) dut_a (
        .clk(clk), .reset(reset), .busy_i(busy), .wakeReq_i(wake), .forceOn_i(force_on),
        .gateAck_i(ack), .gateReq_o(req_a), .clkEn_o(en_a), .ready_o(rdy_a),
        .gated_o(gtd_a), .gateCnt_o(cnt_a));

    clk_gate_ctrl_fg #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(4), .STAT_W(2)) dut_b (
        .clk(clk), .reset(reset), .busy_i(busy), .wakeReq_i(wake), .forceOn_i(force_on),
        .gateAck_i(ack), .gateReq_o(req_b), .clkEn_o(en_b), .ready_o(rdy_b),
        .gated_o(gtd_b), .gateCnt_o(cnt_b));

    typedef struct {
        logic en;
        logic rdy;
        logic gtd;
        logic req;
        int   cnt;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   cycle = 0;

    // Reference model: the stage is either running (counting an idle run),
    // requesting, gated, or counting down a settle window.
    int   m_idle_run = 0;
    bit   m_req = 0;
    bit   m_gated = 0;
    int   m_wake_left = 0;
    int   m_events = 0;

    task automatic check(input string name, input int cyc, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic step(input logic b, input logic w, input logic f, input logic a, input logic r);
        exp_t e;
        bit act;
        busy = b; wake = w; force_on = f; ack = a; reset = r;
        @(posedge clk);
        cycle++;
        act = b | w | f;
        if (r) begin
            m_idle_run = 0; m_req = 0; m_gated = 0; m_wake_left = 0; m_events = 0;
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_gated) begin
            if (act) begin
                m_gated = 0;
                m_wake_left = WAKE;
            end
        end else if (m_req) begin
            if (act) m_req = 0;
            else if (a) begin
                m_req = 0;
                m_gated = 1;
                m_events++;
            end
        end else begin
            m_idle_run = act ? 0 : m_idle_run + 1;
            if (m_idle_run == IDLE) begin
                m_req = 1;
                m_idle_run = 0;
            end
        end
        e.en  = !m_gated;
        e.rdy = !m_gated && (m_wake_left == 0);
        e.gtd = m_gated;
        e.req = m_req;
        e.cnt = m_events;
        e.cyc = cycle;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the outputs are a response; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clkEn", e.cyc, int'(en_a), int'(e.en));
                check("ready", e.cyc, int'(rdy_a), int'(e.rdy));
                check("gated", e.cyc, int'(gtd_a), int'(e.gtd));
                check("gateReq", e.cyc, int'(req_a), int'(e.req));
                check("gateCnt16", e.cyc, int'(cnt_a), (e.cnt > 65535) ? 65535 : e.cnt);
                check("clkEn_w2", e.cyc, int'(en_b), int'(e.en));
                check("ready_w2", e.cyc, int'(rdy_b), int'(e.rdy));
                check("gateReq_w2", e.cyc, int'(req_b), int'(e.req));
                check("gateCnt2", e.cyc, int'(cnt_b), (e.cnt > 3) ? 3 : e.cnt);
            end
        end
    end

    initial begin
        busy = 0; wake = 0; force_on = 0; ack = 0; reset = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Idle to request, acknowledge, then wake with a one-cycle pulse.
        idle(IDLE);
        step(0, 0, 0, 1, 0);
        idle(3);
        step(0, 1, 0, 0, 0);
        idle(4);
        // Busy pulse mid-window restarts the idle run.
        idle(5);
        step(1, 0, 0, 0, 0);
        idle(IDLE + 1);
        // Simultaneous ack and busy in PEND: activity wins.
        step(1, 0, 0, 1, 0);
        idle(IDLE);
        step(0, 0, 0, 1, 0);
        // Force-on holds the clock; also wakes from GATED.
        for (int i = 0; i < 50; i++) step(0, 0, 1, 0, 0);
        idle(IDLE);
        step(0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        // Reset in the middle of the settle window.
        idle(IDLE);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        idle(1);
        // Five gate events to saturate the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            idle(IDLE);
            step(0, 0, 0, 1, 0);
            idle(2);
            step(1, 0, 0, 0, 0);
            idle(WAKE + 1);
        end
        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 499) == 0);
        end
        busy = 0; wake = 0; force_on = 0; ack = 0; reset = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl_fg.md
Name: clk_gate_ctrl_fg

Overview:
- Fine-grained clock-gate enable controller. Sits directly upstream of the fine-grained clock gater cell and drives its enable input.
- Watches activity of one pipeline stage, such as a functional unit or a queue partition. After a programmable idle window it handshakes with the stage to drain it, then deasserts the enable.
- On a wake request it re-enables the clock and holds ready_o low for a fixed settle window.

Parameters:
- IDLE_CYCLES, 8: consecutive idle cycles required before a gate request. Legal range 1..2^CNT_W-1.
- WAKE_CYCLES, 2: cycles from re-enable to ready_o. Legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the idle and wake counters.
- STAT_W, 16: width of the gate-event counter.

Ports:
- clk, in, 1: ungated core clock.
- reset, in, 1: synchronous, active-high.
- busy_i, in, 1: the stage has valid work this cycle. Must be sourced from the ungated domain.
- wakeReq_i, in, 1: upstream has work destined for the stage.
- forceOn_i, in, 1: debug/CSR override that keeps the clock on.
- gateAck_i, in, 1: the stage is drained and safe to gate. Only meaningful while gateReq_o=1.
- gateReq_o, out, 1: request that the stage drain and acknowledge.
- clkEn_o, out, 1: registered enable to the gater's E input.
- ready_o, out, 1: the stage clock is stable and the stage may accept work.
- gated_o, out, 1: status; 1 while in GATED.
- gateCnt_o, out, STAT_W: count of gate events, saturating.

Behaviour:
- All outputs are flops clocked by the ungated clk. Outputs change only at the clk edge, so the enable is glitch-free into the latch-based gate cell.
- "active" = busy_i | wakeReq_i | forceOn_i.
- Reset values: state=ON, clkEn_o=1, ready_o=1, gated_o=0, gateReq_o=0, idleCnt=0, wakeCnt=0, gateCnt_o=0.
- Reset is honoured in any state, including mid-WAKE and mid-PEND.

States:
- ON: clkEn_o=1, ready_o=1, gateReq_o=0.
  - If active: idleCnt<=0.
  - Else: idleCnt<=idleCnt+1.
  - When an idle cycle occurs with idleCnt==IDLE_CYCLES-1: go to PEND and clear idleCnt.
  - Result: with inactivity from cycle t, gateReq_o=1 at t+IDLE_CYCLES.
- PEND: clkEn_o=1, ready_o=1, gateReq_o=1.
  - If active: go to ON with gateReq_o=0. Active takes priority over a simultaneous gateAck_i.
  - Else if gateAck_i: go to GATED.
  - Else stay; there is no timeout.
- GATED: clkEn_o=0, ready_o=0, gated_o=1, gateReq_o=0.
  - If active: go to WAKE and clear wakeCnt.
  - clkEn_o and ready_o change in the same cycle the state register changes.
- WAKE: clkEn_o=1, ready_o=0, gated_o=0.
  - wakeCnt<=wakeCnt+1 each cycle.
  - When wakeCnt==WAKE_CYCLES-1: go to ON.
  - Activity inputs are ignored while in WAKE, since it already terminates in ON.

Latency:
- gateAck_i at cycle u (in PEND, no activity) gives clkEn_o=0 at u+1.
- wakeReq_i at cycle w in GATED gives clkEn_o=1 at w+1 and ready_o=1 at w+1+WAKE_CYCLES.

Gate-event counter:
- gateCnt_o increments by 1 on each PEND->GATED transition.
- It holds at all-ones and does not wrap.

Counters:
- idleCnt and wakeCnt never exceed their limit parameter minus 1. No wrap-around is reachable.

Override:
- forceOn_i is a member of "active". While it is held, GATED and PEND are never entered or held.

Test Plan:
1. Reset, then busy_i=0, wakeReq_i=0, forceOn_i=0 -> gateReq_o rises on the 8th cycle after reset release. Then gateAck_i=1 for 1 cycle -> next cycle clkEn_o=0, gated_o=1, gateCnt_o=1.
2. In GATED, pulse wakeReq_i for 1 cycle at cycle w -> clkEn_o=1 at w+1. ready_o=0 at w+1 and w+2; ready_o=1 at w+3. State is ON.
3. Idle for 5 cycles, busy_i=1 for 1 cycle, then idle -> idleCnt restarts. gateReq_o asserts 8 cycles after the busy pulse, not 3.
4. In PEND, assert gateAck_i=1 and busy_i=1 in the same cycle -> next cycle state=ON, gateReq_o=0, clkEn_o=1, gateCnt_o unchanged.
5. Hold forceOn_i=1 for 50 idle cycles -> gateReq_o stays 0 and clkEn_o stays 1. Assert forceOn_i in GATED -> normal wake sequence as in scenario 2.
6. Assert reset mid-WAKE -> next cycle clkEn_o=1, ready_o=1, gated_o=0, gateCnt_o=0. With STAT_W=2, perform 5 gate events -> gateCnt_o saturates at 3.
